// File: rtl/pq_request_sequencer.sv
// Command front end for the register-tree max-priority queue: buffers client
// requests, issues them one at a time and returns values removed from the root.
module pq_request_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 2047,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 22
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0]            s_op,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  err,
    output logic                  pq_wrt,
    output logic                  pq_read,
    output logic [DATA_WIDTH-1:0] pq_data,
    input  logic                  pq_full,
    input  logic                  pq_empty,
    input  logic [DATA_WIDTH-1:0] pq_top
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    // The settle gap must cover a full compare-and-swap sweep of the tree;
    // the integrator sizes SETTLE_CYCLES, nothing here enforces it.
    if (SETTLE_CYCLES < 2 * $clog2(QUEUE_SIZE)) begin : g_settle_below_tree_depth
    end

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    state_t                state;
    logic [SET_W-1:0]      settle_cnt;

    logic [1:0]            op_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  wr_en;
    logic                  rd_en;
    logic [1:0]            head_op;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  is_push;
    logic                  is_pop;
    logic                  is_repl;
    logic                  eval;
    logic                  drop;
    logic                  stall;
    logic                  launch;

    assign s_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign wr_en     = s_valid && s_ready;
    assign head_op   = op_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign is_push   = (head_op == OP_PUSH);
    assign is_pop    = (head_op == OP_POP);
    assign is_repl   = (head_op == OP_REPL);
    assign eval      = (state == IDLE) && (count != '0);

    // Zero is the tree's empty-slot sentinel, so it can never be stored.
    assign drop   = (head_op == 2'b00)
                 || ((is_push || is_repl) && (head_data == '0))
                 || (is_push && pq_full)
                 || (is_pop && pq_empty);
    assign stall  = (is_pop || is_repl) && r_valid && !r_ready;
    assign launch = eval && !drop && !stall;
    assign rd_en  = eval && (drop || !stall);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            op_mem[wr_ptr]   <= s_op;
            data_mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            settle_cnt <= '0;
            err        <= 1'b0;
            pq_wrt     <= 1'b0;
            pq_read    <= 1'b0;
            pq_data    <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            err <= eval && drop;
            if (r_valid && r_ready) r_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= ISSUE;
                        pq_data <= head_data;
                        pq_wrt  <= is_push || is_repl;
                        // A replace on an empty tree degenerates into a push.
                        pq_read <= is_pop || (is_repl && !pq_empty);
                    end
                end
                ISSUE: begin
                    if (pq_read) begin
                        r_data  <= pq_top;
                        r_valid <= 1'b1;
                    end
                    pq_wrt     <= 1'b0;
                    pq_read    <= 1'b0;
                    settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) state <= IDLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_request_sequencer.sv
// Bench for pq_request_sequencer: a behavioural max-queue stands in for the
// register tree; directed vectors, corner sequences and a random command stream.
module tb_pq_request_sequencer;

    localparam int DW = 8;
    localparam int QS = 7;
    localparam int FD = 4;
    localparam int SC = 6;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    s_op = 2'b00;
    logic [DW-1:0] s_data = '0;
    logic          r_valid;
    logic          r_ready = 1'b1;
    logic [DW-1:0] r_data;
    logic          err;
    logic          pq_wrt;
    logic          pq_read;
    logic [DW-1:0] pq_data;
    logic          pq_full;
    logic          pq_empty;
    logic [DW-1:0] pq_top;

    always #5 CLK = ~CLK;

    pq_request_sequencer #(
        .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .FIFO_DEPTH(FD), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .err(err),
        .pq_wrt(pq_wrt), .pq_read(pq_read), .pq_data(pq_data),
        .pq_full(pq_full), .pq_empty(pq_empty), .pq_top(pq_top)
    );

    // Stand-in for the register tree: a descending-sorted list of keys.
    int            envq[$];
    logic          full_v = 1'b0;
    logic          empty_v = 1'b1;
    logic [DW-1:0] top_v = '0;
    assign pq_full  = full_v;
    assign pq_empty = empty_v;
    assign pq_top   = top_v;

    function automatic void env_insert(int v);
        int i = 0;
        while (i < envq.size() && envq[i] >= v) i++;
        envq.insert(i, v);
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) envq.delete();
        else begin
            if (pq_read && envq.size() > 0) void'(envq.pop_front());
            if (pq_wrt) env_insert(int'(pq_data));
        end
        top_v   <= (envq.size() > 0) ? DW'(envq[0]) : '0;
        empty_v <= (envq.size() == 0);
        full_v  <= (envq.size() >= QS);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor samples just after the falling edge, once inputs have settled,
    // so what it sees is exactly what the next rising edge will act on.
    int            cyc = 0;
    int            err_seen = 0;
    int            results[$];
    int            issue_times[$];
    int            last_issue = -1;
    bit            held_v = 1'b0;
    logic [DW-1:0] held_d = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        #1;
        if (RSTn) begin
            if (err) err_seen++;
            if (r_valid && r_ready) results.push_back(int'(r_data));
            if (pq_wrt || pq_read) begin
                issue_times.push_back(cyc);
                if (last_issue >= 0) check("issue_gap_min", 32'(cyc - last_issue >= SC + 2), 1);
                last_issue = cyc;
            end
            if (held_v) begin
                check("result_held_valid", r_valid, 1);
                check("result_held_data", r_data, held_d);
            end
            held_v = r_valid && !r_ready;
            held_d = r_data;
        end else begin
            held_v     = 1'b0;
            last_issue = -1;
        end
    end

    bit rnd_mode = 1'b0;
    initial forever begin
        @(negedge CLK);
        if (rnd_mode) r_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [1:0] op, input logic [DW-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_op    = op;
        s_data  = d;
        while (!s_ready && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (!s_ready) check("send_timeout", 0, 1);
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_r_valid"}, r_valid, 0);
        check({tag, "_r_data"},  r_data, 0);
        check({tag, "_err"},     err, 0);
        check({tag, "_pq_wrt"},  pq_wrt, 0);
        check({tag, "_pq_read"}, pq_read, 0);
        check({tag, "_pq_data"}, pq_data, 0);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        int            exp_err;
        int            exp_issue;
        bit            exp_res;
        int            exp_val;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int e0, r0, i0, n;
        int mq[$];
        int exp_res[$];
        int exp_err;

        vecs[0]  = '{2'b10, 8'd0, 1, 0, 1'b0, 0};  // pop on empty queue
        vecs[1]  = '{2'b01, 8'd0, 1, 0, 1'b0, 0};  // push of sentinel 0
        vecs[2]  = '{2'b00, 8'd5, 1, 0, 1'b0, 0};  // illegal op
        vecs[3]  = '{2'b01, 8'd4, 0, 1, 1'b0, 0};
        vecs[4]  = '{2'b01, 8'd8, 0, 1, 1'b0, 0};
        vecs[5]  = '{2'b11, 8'd6, 0, 1, 1'b1, 8};  // replace returns old max
        vecs[6]  = '{2'b10, 8'd0, 0, 1, 1'b1, 6};
        vecs[7]  = '{2'b10, 8'd0, 0, 1, 1'b1, 4};
        vecs[8]  = '{2'b11, 8'd3, 0, 1, 1'b0, 0};  // replace on empty acts as push
        vecs[9]  = '{2'b11, 8'd0, 1, 0, 1'b0, 0};  // replace with sentinel 0
        vecs[10] = '{2'b10, 8'd0, 0, 1, 1'b1, 3};

        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        RSTn = 1'b1;
        @(negedge CLK);

        // Back-to-back pushes then pops: sorted results, exact issue spacing.
        e0 = err_seen; r0 = results.size(); i0 = issue_times.size();
        send(2'b01, 8'd5); send(2'b01, 8'd9); send(2'b01, 8'd3);
        send(2'b10, 8'd0); send(2'b10, 8'd0); send(2'b10, 8'd0);
        repeat (60) @(negedge CLK);
        check("seq_issue_count", issue_times.size() - i0, 6);
        check("seq_result_count", results.size() - r0, 3);
        check("seq_err_count", err_seen - e0, 0);
        if (results.size() - r0 == 3) begin
            check("seq_r0", results[r0], 9);
            check("seq_r1", results[r0 + 1], 5);
            check("seq_r2", results[r0 + 2], 3);
        end
        if (issue_times.size() - i0 == 6)
            for (int k = 0; k < 5; k++)
                check("seq_issue_gap", issue_times[i0 + k + 1] - issue_times[i0 + k], SC + 2);

        // Directed single commands.
        for (int v = 0; v < 11; v++) begin
            e0 = err_seen; r0 = results.size(); i0 = issue_times.size();
            send(vecs[v].op, vecs[v].data);
            repeat (SC + 8) @(negedge CLK);
            check($sformatf("vec%0d_err", v), err_seen - e0, vecs[v].exp_err);
            check($sformatf("vec%0d_issue", v), issue_times.size() - i0, vecs[v].exp_issue);
            check($sformatf("vec%0d_res_count", v), results.size() - r0, 32'(vecs[v].exp_res));
            if (vecs[v].exp_res && results.size() > r0)
                check($sformatf("vec%0d_res_val", v), results[r0], vecs[v].exp_val);
        end

        // Result back-pressure stalls the next pop; FIFO fills behind it.
        r_ready = 1'b0;
        e0 = err_seen; r0 = results.size(); i0 = issue_times.size();
        send(2'b01, 8'd4); send(2'b01, 8'd8); send(2'b10, 8'd0); send(2'b10, 8'd0);
        repeat (40) @(negedge CLK);
        check("stall_r_valid", r_valid, 1);
        check("stall_r_data", r_data, 8);
        check("stall_issue_count", issue_times.size() - i0, 3);
        send(2'b01, 8'd11); send(2'b01, 8'd22); send(2'b01, 8'd33);
        check("stall_fifo_full", s_ready, 0);
        r_ready = 1'b1;
        send(2'b01, 8'd44);
        repeat (60) @(negedge CLK);
        check("stall_result_count", results.size() - r0, 2);
        check("stall_err_count", err_seen - e0, 0);
        if (results.size() - r0 == 2) begin
            check("stall_r0", results[r0], 8);
            check("stall_r1", results[r0 + 1], 4);
        end

        // Fill the queue to capacity; one more push is dropped.
        e0 = err_seen; i0 = issue_times.size();
        send(2'b01, 8'd55); send(2'b01, 8'd66); send(2'b01, 8'd77);
        repeat (40) @(negedge CLK);
        send(2'b01, 8'd88);
        repeat (12) @(negedge CLK);
        check("full_err", err_seen - e0, 1);
        check("full_issue", issue_times.size() - i0, 3);

        // Reset during SETTLE with three commands buffered.
        send(2'b10, 8'd0); send(2'b10, 8'd0); send(2'b10, 8'd0); send(2'b10, 8'd0);
        @(negedge CLK);
        #2 RSTn = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        e0 = err_seen; r0 = results.size(); i0 = issue_times.size();
        send(2'b10, 8'd0);
        repeat (SC + 20) @(negedge CLK);
        check("postrst_err", err_seen - e0, 1);
        check("postrst_results", results.size() - r0, 0);
        check("postrst_issue", issue_times.size() - i0, 0);

        // Random commands against a transaction-level model of the queue.
        e0 = err_seen; r0 = results.size();
        exp_err = 0;
        rnd_mode = 1'b1;
        for (int c = 0; c < 120; c++) begin
            int            sel;
            logic [1:0]    op;
            logic [DW-1:0] d;
            int            mx;
            sel = $urandom_range(0, 15);
            op  = (sel == 0) ? 2'b00 : (sel <= 7) ? 2'b01 : (sel <= 12) ? 2'b10 : 2'b11;
            d   = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 255));
            mx  = 0;
            foreach (mq[j]) if (mq[j] > mq[mx]) mx = j;
            case (op)
                2'b00: exp_err++;
                2'b01: if (d == 0 || mq.size() == QS) exp_err++;
                       else mq.push_back(int'(d));
                2'b10: if (mq.size() == 0) exp_err++;
                       else begin exp_res.push_back(mq[mx]); mq.delete(mx); end
                default: if (d == 0) exp_err++;
                         else if (mq.size() == 0) mq.push_back(int'(d));
                         else begin exp_res.push_back(mq[mx]); mq.delete(mx); mq.push_back(int'(d)); end
            endcase
            send(op, d);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 10)) @(negedge CLK);
        end
        n = 0;
        while (n < 6000 && !((results.size() - r0 == exp_res.size()) && (err_seen - e0 == exp_err))) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 6000) check("rand_drain_timeout", 0, 1);
        repeat (SC + 10) @(negedge CLK);
        rnd_mode = 1'b0;
        @(negedge CLK);
        r_ready = 1'b1;
        check("rand_err_count", err_seen - e0, exp_err);
        check("rand_result_count", results.size() - r0, exp_res.size());
        for (int k = 0; k < exp_res.size() && r0 + k < results.size(); k++)
            check($sformatf("rand_res%0d", k), results[r0 + k], exp_res[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
